// File: rtl/arf_rcb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arf_rcb_pkg
//  Description : Shared types and constants for the register-file clock-gate
//                controller: global override mode and channel-count limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package arf_rcb_pkg;

    // Upper bound on the number of gated-clock channels per controller
    localparam int MAX_CH = 32;

    // Global gate override derived from the DFT force-on and power-down inputs
    typedef enum logic [1:0] {
        GATE_NONE      = 2'd0,
        GATE_FORCE_ON  = 2'd1,
        GATE_FORCE_OFF = 2'd2
    } gate_mode_e;

    // Force-on (fd) outranks power-down (rd); with neither, requests rule
    function automatic gate_mode_e gate_mode(input logic fd, input logic rd);
        if (fd) begin
            return GATE_FORCE_ON;
        end else if (rd) begin
            return GATE_FORCE_OFF;
        end else begin
            return GATE_NONE;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/arf_rcb_cg_cell.sv
`default_nettype none
// ============================================================================
//  Module      : arf_rcb_cg_cell
//  Description : Single-channel latch + AND clock gate. Kept in its own module
//                so synthesis can map it onto a library integrated clock gate.
//  Revision    : 1.0 - initial release
// ============================================================================
module arf_rcb_cg_cell (
    input  logic clkb,
    input  logic en,
    output logic clkout
);

    logic en_lat;

    // Transparent while clkb is low, so the enable is frozen for the whole high phase
    always_latch begin
        if (!clkb) begin
            en_lat = en;
        end
    end

    assign clkout = clkb & en_lat;

endmodule
`default_nettype wire

// File: rtl/arf_rcb_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arf_rcb_gate_ctrl
//  Description : Multi-channel register-file clock-gate controller with
//                per-channel idle-hold hysteresis, global force-on (fd),
//                global power-down (rd) and per-channel status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module arf_rcb_gate_ctrl
    import arf_rcb_pkg::*;
#(
    parameter int NUM_CH   = 4,   // 1..MAX_CH
    parameter int HOLD_CYC = 3
) (
    input  logic              clkb,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              fd,
    input  logic              rd,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] idle_pulse
);

    // Hold-counter width; at least one bit even when hysteresis is disabled
    localparam int CNT_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

    gate_mode_e        mode;
    logic [NUM_CH-1:0] hold_busy;
    logic [NUM_CH-1:0] idle_d;
    logic [NUM_CH-1:0] en_eff;
    logic [NUM_CH-1:0] gate_en;
    logic [NUM_CH-1:0] active_q;
    logic [NUM_CH-1:0] idle_pulse_q;

    assign mode = gate_mode(fd, rd);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        if (HOLD_CYC > 0) begin : g_hold
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Power-down kills the hold outright; a request reloads it; otherwise count down to zero
            always_comb begin
                cnt_d = cnt_q;
                if (mode == GATE_FORCE_OFF) begin
                    cnt_d = '0;
                end else if (en[i]) begin
                    cnt_d = CNT_W'(HOLD_CYC);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // Per-channel idle-hold counter
            always_ff @(posedge clkb or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign hold_busy[i] = (cnt_q != '0);
            // Natural expiry only: last hold cycle, no re-request, no power-down
            assign idle_d[i]    = (cnt_q == CNT_W'(1)) & ~en[i] & ~rd;
        end else begin : g_nohold
            assign hold_busy[i] = 1'b0;
            assign idle_d[i]    = 1'b0;
        end

        assign en_eff[i]  = (mode == GATE_FORCE_ON) |
                            ((mode == GATE_NONE) & (en[i] | hold_busy[i]));
        // Reset masks everything except the scan force-on, without waiting for a clock edge
        assign gate_en[i] = rst ? fd : en_eff[i];

        arf_rcb_cg_cell u_cg (
            .clkb   (clkb),
            .en     (gate_en[i]),
            .clkout (clkout[i])
        );
    end

    // Registered status for the power-management sequencer
    always_ff @(posedge clkb or posedge rst) begin
        if (rst) begin
            active_q     <= '0;
            idle_pulse_q <= '0;
        end else begin
            active_q     <= en_eff;
            idle_pulse_q <= idle_d;
        end
    end

    assign active     = active_q;
    assign idle_pulse = idle_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_arf_rcb_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arf_rcb_gate_ctrl
//  Description : Self-checking scoreboard bench for arf_rcb_gate_ctrl
//                (NUM_CH=4, HOLD_CYC=3) with directed hand-computed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arf_rcb_gate_ctrl;

    localparam int  NUM_CH   = 4;
    localparam int  HOLD_CYC = 3;
    localparam time HALF     = 5;

    logic              clkb = 1'b0;
    logic              rst  = 1'b1;
    logic [NUM_CH-1:0] en   = '0;
    logic              fd   = 1'b0;
    logic              rd   = 1'b0;
    logic [NUM_CH-1:0] clkout;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] idle_pulse;

    int checks = 0;
    int errors = 0;

    // Expected response for one clock cycle: clkout in the high phase after
    // the edge, and active/idle_pulse as seen just before that edge
    typedef struct packed {
        logic [3:0] clk;
        logic [3:0] act;
        logic [3:0] idl;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   mon_n = 0;
    time  t_rise = 0;
    bit   rise_seen = 1'b0;

    arf_rcb_gate_ctrl #(
        .NUM_CH   (NUM_CH),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clkb       (clkb),
        .rst        (rst),
        .en         (en),
        .fd         (fd),
        .rd         (rd),
        .clkout     (clkout),
        .active     (active),
        .idle_pulse (idle_pulse)
    );

    always #HALF clkb = ~clkb;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // One cycle of stimulus: drive in the low phase, queue the expected response.
    // With glitch set, en[0] is toggled and restored while clkb is high.
    task automatic step(input logic r_st, input logic [3:0] e, input logic f, input logic r,
                        input logic [3:0] xc, input logic [3:0] xa, input logic [3:0] xi,
                        input bit glitch);
        @(negedge clkb);
        #1;
        rst = r_st;
        en  = e;
        fd  = f;
        rd  = r;
        exp_q.push_back('{clk: xc, act: xa, idl: xi});
        if (glitch) begin
            @(posedge clkb);
            #1 en[0] = ~en[0];
            #1 en[0] = ~en[0];
            #1 en[0] = ~en[0];
            #1 en[0] = ~en[0];
        end
    endtask

    // Monitor: pops one expectation per queued cycle and compares
    initial begin
        forever begin
            @(negedge clkb);
            #3;
            if (exp_q.size() != 0) begin
                mon_x = exp_q.pop_front();
                chk($sformatf("active v%0d", mon_n), 32'(active), 32'(mon_x.act));
                chk($sformatf("idle_pulse v%0d", mon_n), 32'(idle_pulse), 32'(mon_x.idl));
                @(posedge clkb);
                #2;
                chk($sformatf("clkout v%0d", mon_n), 32'(clkout), 32'(mon_x.clk));
                mon_n++;
            end
        end
    end

    // Every clkout[0] high pulse must span the full clkb high phase
    always @(posedge clkout[0]) begin
        t_rise    = $time;
        rise_seen = 1'b1;
    end

    always @(negedge clkout[0]) begin
        if (rise_seen) begin
            chk("clkout0_high_width", 32'($time - t_rise), 32'(HALF));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: requests masked, only fd reaches the gate
        step(1, 4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        step(1, 4'hF, 1, 0, 4'hF, 4'h0, 4'h0, 0);
        step(1, 4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);

        // Hysteresis on ch0: two request cycles plus three hold cycles
        step(0, 4'h1, 0, 0, 4'h1, 4'h0, 4'h0, 0);
        step(0, 4'h1, 0, 0, 4'h1, 4'h1, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h1, 4'h1, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h1, 4'h1, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h1, 4'h1, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h1, 4'h1, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);

        // Rearm on ch1: second request lands when the counter is at 1
        step(0, 4'h2, 0, 0, 4'h2, 4'h0, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h2, 4'h2, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h2, 4'h2, 4'h0, 0);
        step(0, 4'h2, 0, 0, 4'h2, 4'h2, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h2, 4'h2, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h2, 4'h2, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h2, 4'h2, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h2, 4'h2, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);

        // Overrides: rd kills the ch2 hold, rd beats en, fd beats rd
        step(0, 4'h4, 0, 0, 4'h4, 4'h0, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h4, 4'h4, 4'h0, 0);
        step(0, 4'h0, 0, 1, 4'h0, 4'h4, 4'h0, 0);
        step(0, 4'hF, 0, 1, 4'h0, 4'h0, 4'h0, 0);
        step(0, 4'h0, 1, 1, 4'hF, 4'h0, 4'h0, 0);
        step(0, 4'h0, 1, 1, 4'hF, 4'hF, 4'h0, 0);
        step(0, 4'h0, 0, 1, 4'h0, 4'hF, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);

        // Mid-operation asynchronous reset during a ch3 hold (count = 2)
        step(0, 4'h8, 0, 0, 4'h8, 4'h0, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h8, 4'h8, 4'h0, 0);
        @(posedge clkb);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst active", 32'(active), 32'h0);
        chk("async_rst idle_pulse", 32'(idle_pulse), 32'h0);
        chk("async_rst clkout_high_kept", 32'(clkout), 32'h8);
        step(1, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        step(0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 0);

        // Glitch check: en[0] toggled while clkb is high must not disturb anything
        step(0, 4'h1, 0, 0, 4'h1, 4'h0, 4'h0, 1);
        step(0, 4'h0, 0, 0, 4'h1, 4'h1, 4'h0, 1);
        step(0, 4'h1, 0, 0, 4'h1, 4'h1, 4'h0, 1);
        step(0, 4'h1, 0, 0, 4'h1, 4'h1, 4'h0, 1);
        step(0, 4'h0, 0, 0, 4'h1, 4'h1, 4'h0, 1);
        step(0, 4'h0, 0, 0, 4'h1, 4'h1, 4'h0, 1);
        step(0, 4'h0, 0, 0, 4'h1, 4'h1, 4'h0, 1);
        step(0, 4'h0, 0, 0, 4'h0, 4'h1, 4'h1, 1);
        step(0, 4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 1);

        repeat (3) @(negedge clkb);
        chk("queue_drain", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
